// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST FC-layer operand path.
`timescale 1ns/1ps
package mnist_pkg;

    localparam int unsigned LANES    = 4;
    localparam int unsigned RESULT_W = 26;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned DATA_W   = LANES * 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } feeder_state_t;

    // Control sideband travelling with one 32-bit operand beat.
    typedef struct packed {
        logic             flush;
        logic             last;
        logic [LANES-1:0] valid;
    } beat_t;

    // Number of packed words needed to hold vec_len int8 elements.
    function automatic int unsigned words(input int unsigned vec_len);
        return (vec_len + LANES - 1) / LANES;
    endfunction

    // Lane-valid mask of the final word of a vector.
    function automatic logic [LANES-1:0] tail_mask(input int unsigned vec_len);
        int unsigned rem;
        rem = vec_len % LANES;
        if (rem == 0) begin
            return {LANES{1'b1}};
        end
        return LANES'((32'd1 << rem) - 32'd1);
    endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// Word/neuron counters and feature/weight buffer address generation.
`timescale 1ns/1ps
module feeder_addr_gen
    import mnist_pkg::*;
#(
    parameter int unsigned VEC_LEN     = 784,
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned FEAT_AW     = 8,
    parameter int unsigned WGT_AW      = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               step,
    input  logic               next_neuron,
    output logic [FEAT_AW-1:0] feat_addr,
    output logic [WGT_AW-1:0]  wgt_addr,
    output logic [IDX_W-1:0]   neuron,
    output logic               first_word_c,
    output logic               last_word_c,
    output logic               last_neuron_c
);

    localparam int unsigned        WORDS       = words(VEC_LEN);
    localparam logic [FEAT_AW-1:0] LAST_WORD   = FEAT_AW'(WORDS - 1);
    localparam logic [IDX_W-1:0]   LAST_NEURON = IDX_W'(NUM_NEURONS - 1);

    // Position flags decoded from the current word and neuron counters.
    assign first_word_c  = (feat_addr == '0);
    assign last_word_c   = (feat_addr == LAST_WORD);
    assign last_neuron_c = (neuron == LAST_NEURON);

    // The weight address runs contiguously across neurons, so it only ever
    // increments: the row base of neuron n+1 is one past the last word of n.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            feat_addr <= '0;
            wgt_addr  <= '0;
            neuron    <= '0;
        end else if (step && !last_word_c) begin
            feat_addr <= feat_addr + FEAT_AW'(1);
            wgt_addr  <= wgt_addr + WGT_AW'(1);
        end else if (next_neuron) begin
            feat_addr <= '0;
            wgt_addr  <= wgt_addr + WGT_AW'(1);
            neuron    <= neuron + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mac_feeder.sv
// Operand streamer feeding the 4-lane MAC controller, one pass per neuron.
// Optional ReLU on captured results: define MAC_FEEDER_RELU_EN.
`timescale 1ns/1ps
module mac_feeder
    import mnist_pkg::*;
#(
    parameter int unsigned VEC_LEN     = 784,
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned FEAT_AW     = 8,
    parameter int unsigned WGT_AW      = 11,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done_all,
    output logic                       err,
    output logic [FEAT_AW-1:0]         feat_addr,
    input  logic [DATA_W-1:0]          feat_rdata,
    output logic [WGT_AW-1:0]          wgt_addr,
    input  logic [DATA_W-1:0]          wgt_rdata,
    output logic                       mac_en,
    output logic                       mac_flush,
    output logic [LANES-1:0]           mac_valid,
    output logic                       mac_last,
    output logic [DATA_W-1:0]          mac_feature,
    output logic [DATA_W-1:0]          mac_weight,
    input  logic                       mac_done,
    input  logic signed [RESULT_W-1:0] mac_result,
    output logic                       res_valid,
    output logic [IDX_W-1:0]           res_idx,
    output logic signed [RESULT_W-1:0] res_data
);

    localparam logic [LANES-1:0]  TAIL      = tail_mask(VEC_LEN);
    localparam int unsigned       TCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    feeder_state_t     state;
    logic [TCNT_W-1:0] tcnt;
    beat_t             beat;

    logic             clear;
    logic             step;
    logic             next_neuron;
    logic [IDX_W-1:0] neuron;
    logic             first_word_c;
    logic             last_word_c;
    logic             last_neuron_c;

    // Result shaping applied at capture time.
    function automatic logic signed [RESULT_W-1:0] shape_result(
        input logic signed [RESULT_W-1:0] r
    );
`ifdef MAC_FEEDER_RELU_EN
        return r[RESULT_W-1] ? '0 : r;
`else
        return r;
`endif
    endfunction

    // Counter controls decoded from the FSM state.
    assign clear       = (state == ST_IDLE) && start;
    assign step        = (state == ST_STREAM);
    assign next_neuron = (state == ST_WAIT) && mac_done && !last_neuron_c;

    feeder_addr_gen #(
        .VEC_LEN     (VEC_LEN),
        .NUM_NEURONS (NUM_NEURONS),
        .FEAT_AW     (FEAT_AW),
        .WGT_AW      (WGT_AW)
    ) u_addr_gen (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .step          (step),
        .next_neuron   (next_neuron),
        .feat_addr     (feat_addr),
        .wgt_addr      (wgt_addr),
        .neuron        (neuron),
        .first_word_c  (first_word_c),
        .last_word_c   (last_word_c),
        .last_neuron_c (last_neuron_c)
    );

    // Operand data comes straight from the buffers; the sideband is delayed
    // one cycle so it lines up with the synchronous-read data.
    assign mac_feature = feat_rdata;
    assign mac_weight  = wgt_rdata;
    assign mac_flush   = beat.flush;
    assign mac_last    = beat.last;
    assign mac_valid   = beat.valid;

    // Pass sequencing, beat sideband, timeout and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            beat      <= '0;
            busy      <= 1'b0;
            done_all  <= 1'b0;
            err       <= 1'b0;
            mac_en    <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
        end else begin
            beat      <= '0;
            res_valid <= 1'b0;
            done_all  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mac_en <= 1'b0;
                    if (start) begin
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    mac_en     <= 1'b1;
                    beat.flush <= first_word_c;
                    beat.last  <= last_word_c;
                    beat.valid <= last_word_c ? TAIL : {LANES{1'b1}};
                    if (last_word_c) begin
                        tcnt  <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mac_done) begin
                        mac_en    <= 1'b0;
                        res_valid <= 1'b1;
                        res_idx   <= neuron;
                        res_data  <= shape_result(mac_result);
                        if (last_neuron_c) begin
                            done_all <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            state <= ST_STREAM;
                        end
                    end else if (tcnt == TCNT_LAST) begin
                        mac_en   <= 1'b0;
                        err      <= 1'b1;
                        done_all <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                default: begin
                    mac_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder with a cycle-level reference model.
`timescale 1ns/1ps
module tb_mac_feeder;

    localparam int VEC_LEN     = 6;
    localparam int NUM_NEURONS = 3;
    localparam int FEAT_AW     = 2;
    localparam int WGT_AW      = 3;
    localparam int TIMEOUT     = 15;
    localparam int WORDS       = (VEC_LEN + 3) / 4;
    localparam int REM         = VEC_LEN % 4;
    localparam logic [3:0]  TAIL    = (REM == 0) ? 4'hF : 4'((1 << REM) - 1);
    localparam logic [25:0] NEG50   = 26'h3FFFFCE;
`ifdef MAC_FEEDER_RELU_EN
    localparam logic [25:0] NEG50_Q = 26'd0;
`else
    localparam logic [25:0] NEG50_Q = 26'h3FFFFCE;
`endif

    logic               clk;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done_all;
    logic               err;
    logic [FEAT_AW-1:0] feat_addr;
    logic [31:0]        feat_rdata;
    logic [WGT_AW-1:0]  wgt_addr;
    logic [31:0]        wgt_rdata;
    logic               mac_en;
    logic               mac_flush;
    logic [3:0]         mac_valid;
    logic               mac_last;
    logic [31:0]        mac_feature;
    logic [31:0]        mac_weight;
    logic               mac_done;
    logic [25:0]        mac_result;
    logic               res_valid;
    logic [3:0]         res_idx;
    logic [25:0]        res_data;

    mac_feeder #(
        .VEC_LEN     (VEC_LEN),
        .NUM_NEURONS (NUM_NEURONS),
        .FEAT_AW     (FEAT_AW),
        .WGT_AW      (WGT_AW),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done_all    (done_all),
        .err         (err),
        .feat_addr   (feat_addr),
        .feat_rdata  (feat_rdata),
        .wgt_addr    (wgt_addr),
        .wgt_rdata   (wgt_rdata),
        .mac_en      (mac_en),
        .mac_flush   (mac_flush),
        .mac_valid   (mac_valid),
        .mac_last    (mac_last),
        .mac_feature (mac_feature),
        .mac_weight  (mac_weight),
        .mac_done    (mac_done),
        .mac_result  (mac_result),
        .res_valid   (res_valid),
        .res_idx     (res_idx),
        .res_data    (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Feature and weight buffers with one-cycle synchronous read.
    logic [31:0] feat_mem [4];
    logic [31:0] wgt_mem  [8];
    always @(posedge clk) begin
        feat_rdata <= feat_mem[feat_addr];
        wgt_rdata  <= wgt_mem[wgt_addr];
    end

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    bit resp_en = 1'b0;
    bit force_res = 1'b0;
    int wlog [$];
    int ridx [$];
    logic [25:0] rdat [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [25:0] exp_res(input logic [25:0] r);
`ifdef MAC_FEEDER_RELU_EN
        return r[25] ? 26'd0 : r;
`else
        return r;
`endif
    endfunction

    // Reference model: m_t counts cycles since a neuron's streaming began;
    // beats occupy t=1..WORDS, waiting starts at t=WORDS.
    bit          m_act = 1'b0;
    int          m_t   = 0;
    int          m_neu = 0;
    logic        e_busy, e_done_all, e_err, e_res_valid;
    logic [3:0]  e_res_idx;
    logic [25:0] e_res_data;

    always @(posedge clk) begin
        e_res_valid = 1'b0;
        e_done_all  = 1'b0;
        if (rst) begin
            m_act = 1'b0; m_t = 0; m_neu = 0;
            e_err = 1'b0; e_res_idx = 4'd0; e_res_data = 26'd0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1'b1; m_t = 0; m_neu = 0; e_err = 1'b0;
            end
        end else if (m_t < WORDS) begin
            m_t++;
        end else if (mac_done) begin
            e_res_valid = 1'b1;
            e_res_idx   = 4'(m_neu);
            e_res_data  = exp_res(mac_result);
            if (m_neu == NUM_NEURONS - 1) begin
                m_act = 1'b0; e_done_all = 1'b1;
            end else begin
                m_neu++; m_t = 0;
            end
        end else if (m_t - WORDS + 1 >= TIMEOUT) begin
            e_err = 1'b1; e_done_all = 1'b1; m_act = 1'b0;
        end else begin
            m_t++;
        end
        e_busy = m_act;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit beat;
        if (chk_on) begin
            beat = m_act && m_t >= 1 && m_t <= WORDS;
            chk("busy", busy, e_busy);
            chk("done_all", done_all, e_done_all);
            chk("err", err, e_err);
            chk("res_valid", res_valid, e_res_valid);
            chk("res_idx", res_idx, e_res_idx);
            chk("res_data", res_data, e_res_data);
            chk("mac_en", mac_en, m_act && m_t >= 1);
            chk("mac_flush", mac_flush, beat && m_t == 1);
            chk("mac_last", mac_last, beat && m_t == WORDS);
            chk("mac_valid", mac_valid, beat ? ((m_t == WORDS) ? TAIL : 4'hF) : 4'h0);
            if (beat) begin
                chk("mac_feature", mac_feature, feat_mem[m_t-1]);
                chk("mac_weight", mac_weight, wgt_mem[m_neu*WORDS + m_t - 1]);
            end
            if (m_act && m_t < WORDS) begin
                chk("feat_addr", feat_addr, 32'(m_t));
                chk("wgt_addr", wgt_addr, 32'(m_neu*WORDS + m_t));
                if (m_neu == 1) wlog.push_back(int'(wgt_addr));
            end
            if (res_valid) begin
                ridx.push_back(int'(res_idx));
                rdat.push_back(res_data);
            end
        end
    end

    // MAC controller stand-in: spurious done during streaming, real done a
    // few cycles after the last beat.
    initial begin
        int rcnt;
        rcnt = 0;
        mac_done = 1'b0;
        mac_result = 26'd0;
        forever begin
            @(posedge clk); #1;
            mac_done = 1'b0;
            if (resp_en && m_act && !rst) begin
                if (m_t < WORDS) begin
                    if ($urandom % 4 == 0) begin
                        mac_done = 1'b1;
                        mac_result = 26'($urandom);
                    end
                end else if (m_t == WORDS) begin
                    rcnt = $urandom_range(0, 5);
                end else if (rcnt == 0) begin
                    mac_done = 1'b1;
                    mac_result = force_res ? NEG50 : 26'($urandom);
                end else begin
                    rcnt--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Leaves the caller in the first cycle after start is accepted.
    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit inj, output int n);
        n = 0;
        while (!done_all) begin
            if (n >= limit) begin
                total++; bad++;
                $display("FAIL wait_done: no done_all after %0d cycles", n);
                break;
            end
            tick();
            start = 1'b0;
            n++;
            if (!done_all && inj) start = ($urandom % 8 == 0);
        end
        start = 1'b0;
    endtask

    initial begin
        int n;
        int n0;
        int rst_at;
        for (int i = 0; i < 4; i++) feat_mem[i] = $urandom;
        for (int i = 0; i < 8; i++) wgt_mem[i] = $urandom;
        rst = 1'b1;
        start = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done_all", done_all, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_feat_addr", feat_addr, 0);
        chk("rst_res_valid", res_valid, 0);

        // Directed pass: beat shape, ignored start, address and result order.
        wlog.delete(); ridx.delete(); rdat.delete();
        resp_en = 1'b1;
        force_res = 1'b1;
        start_pass();
        chk("busy_after_start", busy, 1);
        tick();
        chk("b0_en", mac_en, 1);
        chk("b0_flush", mac_flush, 1);
        chk("b0_last", mac_last, 0);
        chk("b0_valid", mac_valid, 4'hF);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b1_flush", mac_flush, 0);
        chk("b1_last", mac_last, 1);
        chk("b1_valid", mac_valid, 4'b0011);
        wait_done(300, 1'b0, n);
        tick();
        force_res = 1'b0;
        chk("wlog_size", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            chk("wlog0", wlog[0], 2);
            chk("wlog1", wlog[1], 3);
        end
        chk("ridx_size", ridx.size(), 3);
        if (ridx.size() >= 3) begin
            chk("ridx0", ridx[0], 0);
            chk("ridx1", ridx[1], 1);
            chk("ridx2", ridx[2], 2);
            chk("rdat0_neg50", rdat[0], NEG50_Q);
        end

        // Timeout: no mac_done at all.
        resp_en = 1'b0;
        n0 = ridx.size();
        start_pass();
        wait_done(100, 1'b0, n);
        chk("to_cycles", n, 17);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        tick();
        chk("to_no_res", ridx.size(), n0);
        chk("to_err_sticky", err, 1);
        resp_en = 1'b1;
        start_pass();
        chk("err_cleared", err, 0);
        wait_done(300, 1'b0, n);
        tick();

        // Reset on beat 1 of neuron 0, with a coincident start.
        start_pass();
        tick();
        tick();
        chk("rb_on_beat1", mac_last, 1);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("rm_busy", busy, 0);
        chk("rm_mac_en", mac_en, 0);
        chk("rm_valid", mac_valid, 0);
        chk("rm_flush", mac_flush, 0);
        chk("rm_last", mac_last, 0);
        chk("rm_feat_addr", feat_addr, 0);
        chk("rm_wgt_addr", wgt_addr, 0);
        chk("rm_done_all", done_all, 0);
        tick();
        start_pass();
        tick();
        chk("replay_flush", mac_flush, 1);
        wait_done(300, 1'b0, n);
        tick();

        // Randomised passes with stray starts and occasional resets.
        for (int p = 0; p < 40; p++) begin
            rst_at = ($urandom % 6 == 0) ? int'($urandom_range(1, 8)) : 0;
            start_pass();
            if (rst_at != 0) begin
                repeat (rst_at) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                wait_done(400, 1'b1, n);
                tick();
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Operand streamer that drives the 4-lane MAC controller from on-chip feature and weight buffers.
- One pass per output neuron:
  - reads VEC_LEN packed int8 features and the matching weight row;
  - issues 32-bit beats with a per-byte valid mask, a flush on the first beat and last on the final beat;
  - waits for the controller's done, then captures the 26-bit accumulated result.
- Sits between the FC-layer sequencer (start/done_all) and mac_controller.

Parameters:
- VEC_LEN, 784, int8 elements per dot product (MNIST 28x28).
- NUM_NEURONS, 10, output neurons per layer pass.
- FEAT_AW, 8, feature buffer word-address width (must hold ceil(VEC_LEN/4)-1).
- WGT_AW, 11, weight buffer word-address width (must hold NUM_NEURONS*ceil(VEC_LEN/4)-1).
- TIMEOUT, 255, maximum cycles to wait for mac_done after the last beat.

Ports:
- clk  in  1  clock; one clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse starting a layer pass; ignored while busy=1.
- busy  out  1  high from the cycle after accepted start until done_all.
- done_all  out  1  one-cycle pulse after the last neuron's result.
- err  out  1  sticky timeout flag; cleared only by rst or by an accepted start.
- feat_addr  out  FEAT_AW  feature buffer read address; synchronous read, 1-cycle latency.
- feat_rdata  in  32  4 packed int8 features, byte0 = lowest element index.
- wgt_addr  out  WGT_AW  weight buffer read address; same timing as feat_addr.
- wgt_rdata  in  32  4 packed int8 weights.
- mac_en  out  1  controller enable.
- mac_flush  out  1  first beat of a neuron.
- mac_valid  out  4  per-byte lane valid.
- mac_last  out  1  final beat of a neuron.
- mac_feature  out  32  equals feat_rdata.
- mac_weight  out  32  equals wgt_rdata.
- mac_done  in  1  controller result-ready pulse.
- mac_result  in  26  signed accumulated dot product.
- res_valid  out  1  one-cycle pulse, result captured.
- res_idx  out  4  neuron index of the result.
- res_data  out  26  signed result.

Behaviour:
- Derived constants:
  - WORDS = ceil(VEC_LEN/4).
  - REM = VEC_LEN mod 4.
  - TAIL_MASK = 4'b1111 if REM==0, else (1<<REM)-1.
- Reset: all outputs 0; FSM=IDLE; counters 0.
- FSM states: IDLE, STREAM, WAIT.
- IDLE:
  - mac_en=0.
  - On start: neuron=0, word=0, err cleared, go to STREAM.
- STREAM, each cycle:
  - feat_addr=word, wgt_addr=neuron*WORDS+word, word increments.
  - The beat is presented one cycle later, aligned with rdata:
    - mac_valid = TAIL_MASK on the last word, else 4'b1111;
    - mac_flush=1 on word 0 only;
    - mac_last=1 on word WORDS-1 only.
  - After issuing word WORDS-1, go to WAIT.
- mac_en: 1 from the first beat through the cycle mac_done is sampled; 0 otherwise.
- mac_valid, mac_flush, mac_last are 0 on any cycle without a beat.
- WAIT:
  - Timeout counter starts at 0.
  - On mac_done=1:
    - res_data<=mac_result, res_idx<=neuron, res_valid pulses next cycle.
    - If neuron==NUM_NEURONS-1: pulse done_all, busy=0, go to IDLE.
    - Else: neuron++, word=0, go to STREAM.
  - If the counter reaches TIMEOUT: err=1, done_all pulses, go to IDLE, no res_valid.
- Timing:
  - Throughput: WORDS beats back-to-back, no bubbles within a neuron.
  - Start-to-first-beat latency: 2 cycles.
- Boundary conditions:
  - mac_done arriving during STREAM (spurious) is ignored.
  - start coincident with rst: rst wins.
  - rst mid-pass: immediate return to IDLE with all outputs 0; no done_all.
  - WORDS==1: the single beat carries flush=1, last=1, valid=TAIL_MASK.
  - res_data is sign-preserved, no saturation.

Optional Feature:
- Macro: MAC_FEEDER_RELU_EN.
- Defined: res_data = 0 when mac_result is negative, else mac_result.
- Undefined: res_data = mac_result unchanged.
- res_valid and res_idx timing are identical either way.

Decomposition:
- Shared package mnist_pkg holds:
  - constants LANES=4, RESULT_W=26;
  - FSM state enum;
  - function tail_mask(VEC_LEN).
- One sub-module, feeder_addr_gen: word/neuron counters and address arithmetic.
- FSM and beat alignment stay in mac_feeder.

Test Plan:
- VEC_LEN=8, NUM_NEURONS=1, start:
  - 2 beats; beat0 flush=1 last=0 valid=4'hF; beat1 flush=0 last=1 valid=4'hF.
  - Then mac_done with mac_result=26'sd100 -> res_valid, res_idx=0, res_data=100, then done_all.
- VEC_LEN=6, NUM_NEURONS=2:
  - Beats per neuron are 2; second beat has valid=4'b0011.
  - Neuron 1 wgt_addr sequence is 2,3.
  - Two res_valid pulses with res_idx 0 then 1.
- mac_result=-26'sd50:
  - res_data=-50 without MAC_FEEDER_RELU_EN.
  - res_data=0 with MAC_FEEDER_RELU_EN.
- mac_done never asserted, TIMEOUT=15:
  - err=1 after 15 WAIT cycles, done_all pulses, no res_valid.
  - Next start clears err.
- rst asserted on beat 1 of neuron 0:
  - Next cycle all outputs 0, busy=0.
  - A new start replays from word 0 with flush=1.
- start pulsed while busy=1: ignored; beat sequence and res_idx unchanged.
